// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants for the decoder output bit packer
// Purpose: default packer geometry, statistics counter width and a width helper.
// Ports: none (package).
package viterbi_pkg;

  localparam int DEF_OUT_W      = 8;
  localparam int DEF_IN_W       = 1;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int STATS_W        = 16;

  // Width of a bit count that must hold 0..out_w inclusive.
  function automatic int nbits_w(input int out_w);
    return $clog2(out_w) + 1;
  endfunction

endpackage

// File: rtl/pack_fifo.sv
// rtl/pack_fifo.sv - synchronous output FIFO for packed words
// Purpose: DEPTH-entry FIFO, power-of-2 depth, show-ahead read (head visible while not empty).
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_push, i_push_data write request and data (accepted when not full, or full with a pop)
//   i_pop               read request (ignored when empty)
//   o_rd_data           head entry, zero while empty
//   o_full, o_empty     occupancy flags
module pack_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra wrap bit on each pointer separates full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/bit_packer_param.sv
// rtl/bit_packer_param.sv - packs IN_W-bit decoded beats into OUT_W-bit words
// Purpose: accumulates input beats into words (LSB- or MSB-first), flushes partial
//   words on in_last, and queues words in pack_fifo toward the sink.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   in_valid/in_ready/in_bits/in_last   input beat handshake (in_bits[0] earliest)
//   out_valid/out_ready                 output word handshake
//   out_word/out_nbits/out_last         packed word, valid bit count, frame end
//   word_cnt/frame_cnt                  popped words / popped frame-ending words
//                                       (only when BIT_PACKER_STATS_EN is defined)
module bit_packer_param
  import viterbi_pkg::*;
#(
  parameter int OUT_W      = DEF_OUT_W,
  parameter int IN_W       = DEF_IN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MSB_FIRST  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_bits,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_word,
  output logic [$clog2(OUT_W):0] out_nbits,
  output logic                   out_last
`ifdef BIT_PACKER_STATS_EN
  ,
  output logic [STATS_W-1:0]     word_cnt,
  output logic [STATS_W-1:0]     frame_cnt
`endif
);

  localparam int CW = nbits_w(OUT_W);
  localparam int FW = OUT_W + CW + 1;

  if (OUT_W < 2) begin : g_chk_out_w
    $error("bit_packer_param: OUT_W must be >= 2");
  end
  if ((IN_W < 1) || ((OUT_W % IN_W) != 0)) begin : g_chk_in_w
    $error("bit_packer_param: IN_W must divide OUT_W");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("bit_packer_param: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic [OUT_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [IN_W-1:0]  w_bits_rev;
  logic [OUT_W-1:0] w_ins;
  logic [OUT_W-1:0] w_acc_next;
  logic [CW-1:0]    w_cnt_sum;
  logic             w_fire;
  logic             w_push;
  logic [FW-1:0]    w_push_data;
  logic [FW-1:0]    w_rd_data;
  logic             w_full;
  logic             w_empty;

  // New bits land right after those already held: growing up from bit 0 when
  // LSB-first, growing down from bit OUT_W-1 when MSB-first. Both forms give the
  // required alignment for partial words without any extra shifting at flush.
  always_comb begin
    w_bits_rev = '0;
    for (int k = 0; k < IN_W; k++) w_bits_rev[k] = in_bits[IN_W-1-k];
    if (MSB_FIRST != 0) w_ins = (OUT_W'(w_bits_rev) << (OUT_W - IN_W)) >> r_cnt;
    else                w_ins = OUT_W'(in_bits) << r_cnt;
  end

  assign w_acc_next  = r_acc | w_ins;
  assign w_cnt_sum   = r_cnt + CW'(IN_W);
  assign in_ready    = rst_n && !w_full;
  assign w_fire      = in_valid && in_ready;
  assign w_push      = w_fire && ((w_cnt_sum == CW'(OUT_W)) || in_last);
  assign w_push_data = {in_last, w_cnt_sum, w_acc_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_fire) begin
      if (w_push) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_sum;
      end
    end
  end

  pack_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (out_ready),
    .o_rd_data   (w_rd_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_word  = w_rd_data[OUT_W-1:0];
  assign out_nbits = w_rd_data[OUT_W +: CW];
  assign out_last  = w_rd_data[FW-1];

`ifdef BIT_PACKER_STATS_EN
  logic [STATS_W-1:0] r_word_cnt;
  logic [STATS_W-1:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt  <= '0;
      r_frame_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_word_cnt <= r_word_cnt + STATS_W'(1);
      if (out_last) r_frame_cnt <= r_frame_cnt + STATS_W'(1);
    end
  end

  assign word_cnt  = r_word_cnt;
  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_bit_packer_param.sv
// tb/tb_bit_packer_param.sv - directed self-checking bench for bit_packer_param
module tb_bit_packer_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  // A (defaults) and B (MSB_FIRST=1) share inputs.
  logic       a_in_valid, a_in_bits, a_in_last, a_out_ready;
  logic       a_in_ready, a_out_valid, a_out_last;
  logic [7:0] a_out_word;
  logic [3:0] a_out_nbits;
  logic       b_in_ready, b_out_valid, b_out_last;
  logic [7:0] b_out_word;
  logic [3:0] b_out_nbits;
  // C: IN_W=2.
  logic       c_in_valid, c_in_last, c_out_ready;
  logic [1:0] c_in_bits;
  logic       c_in_ready, c_out_valid, c_out_last;
  logic [7:0] c_out_word;
  logic [3:0] c_out_nbits;
`ifdef BIT_PACKER_STATS_EN
  logic [15:0] a_wc, a_fc, b_wc, b_fc, c_wc, c_fc;
`endif

  bit_packer_param u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_bits(a_in_bits), .in_last(a_in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_word(a_out_word), .out_nbits(a_out_nbits),
    .out_last(a_out_last)
`ifdef BIT_PACKER_STATS_EN
    , .word_cnt(a_wc), .frame_cnt(a_fc)
`endif
  );

  bit_packer_param #(.MSB_FIRST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(b_in_ready),
    .in_bits(a_in_bits), .in_last(a_in_last), .out_valid(b_out_valid),
    .out_ready(a_out_ready), .out_word(b_out_word), .out_nbits(b_out_nbits),
    .out_last(b_out_last)
`ifdef BIT_PACKER_STATS_EN
    , .word_cnt(b_wc), .frame_cnt(b_fc)
`endif
  );

  bit_packer_param #(.IN_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_bits(c_in_bits), .in_last(c_in_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_word(c_out_word), .out_nbits(c_out_nbits),
    .out_last(c_out_last)
`ifdef BIT_PACKER_STATS_EN
    , .word_cnt(c_wc), .frame_cnt(c_fc)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic b, input logic l);
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_bits  = b;
    a_in_last  = l;
  endtask

  task automatic idle_a();
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic pop_a();
    @(negedge clk);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  logic [7:0] v33;
  logic [1:0] cv [4];
  logic [7:0] exp_w [5];
  logic [7:0] got [5];
  int idx, stall_at, nw;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_bits = 1'b0; a_in_last = 1'b0; a_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_bits = 2'b00; c_in_last = 1'b0; c_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  a_in_ready,  0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_word",  a_out_word,  0);
    chk("rst_out_nbits", a_out_nbits, 0);
    chk("rst_out_last",  a_out_last,  0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", a_in_ready, 1);

    // 1,0,1,1,0,0,1,0 in time order
    v33 = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      send_a(v33[i], 1'b0);
      if (i == 7) chk("lat_not_early", a_out_valid, 0);
    end
    idle_a();
    chk("w8_valid", a_out_valid, 1);
    chk("w8_word",  a_out_word,  8'h4D);
    chk("w8_nbits", a_out_nbits, 8);
    chk("w8_last",  a_out_last,  0);
    chk("w8_msb_word", b_out_word, 8'hB2);

    send_a(1'b1, 1'b0);
    send_a(1'b1, 1'b0);
    send_a(1'b1, 1'b1);
    idle_a();
    chk("part_valid", a_out_valid, 1);
    chk("part_word",  a_out_word,  8'h07);
    chk("part_nbits", a_out_nbits, 3);
    chk("part_last",  a_out_last,  1);
    chk("part_msb_word",  b_out_word,  8'hE0);
    chk("part_msb_nbits", b_out_nbits, 3);
    chk("part_msb_last",  b_out_last,  1);

    cv[0] = 2'b01; cv[1] = 2'b10; cv[2] = 2'b11; cv[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c_in_valid = 1'b1;
      c_in_bits  = cv[i];
    end
    @(negedge clk);
    c_in_valid = 1'b0;
    chk("inw2_valid", c_out_valid, 1);
    chk("inw2_word",  c_out_word,  8'h39);
    chk("inw2_nbits", c_out_nbits, 8);

    // Backpressure: fill the FIFO, then drain and compare order.
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h5A; exp_w[3] = 8'hC3; exp_w[4] = 8'h81;
    @(negedge clk);
    a_out_ready = 1'b0;
    idx = 0; stall_at = -1; nw = 0;
    for (int cyc = 0; cyc < 60 && stall_at < 0; cyc++) begin
      @(negedge clk);
      if (a_in_ready) begin
        a_in_valid = 1'b1;
        a_in_bits  = exp_w[idx/8][idx%8];
        idx++;
      end else begin
        a_in_valid = 1'b0;
        stall_at = idx;
      end
    end
    chk("bp_stall_bits", stall_at, 32);
    chk("bp_head_word",  a_out_word, 8'h11);
    @(negedge clk);
    chk("bp_hold_ready", a_in_ready, 0);
    chk("bp_hold_word",  a_out_word, 8'h11);
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (a_out_valid) begin
        if (nw < 5) got[nw] = a_out_word;
        nw++;
      end
      if (a_in_ready && idx < 40) begin
        a_in_valid = 1'b1;
        a_in_bits  = exp_w[idx/8][idx%8];
        idx++;
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("bp_word_count", nw, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_word%0d", i), got[i], exp_w[i]);
    chk("bp_drained", a_out_valid, 0);

    // Reset mid-frame discards the 5 held bits.
    for (int i = 0; i < 5; i++) send_a(1'b1, 1'b0);
    @(negedge clk);
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready",  a_in_ready,  0);
    chk("midrst_out_valid", a_out_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_a(1'b1, 1'b0);
    idle_a();
    chk("midrst_word",  a_out_word,  8'hFF);
    chk("midrst_nbits", a_out_nbits, 8);
    send_a(1'b0, 1'b1);
    idle_a();
    chk("midrst_resid_nbits", a_out_nbits, 1);
    chk("midrst_resid_word",  a_out_word,  8'h00);
    chk("midrst_resid_last",  a_out_last,  1);

    // Two 12-bit frames queued under backpressure.
    @(negedge clk);
    rst_n = 1'b0;
    a_out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 11; i++) send_a(1'b1, 1'b0);
      send_a(1'b1, 1'b1);
    end
    idle_a();
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("fr%0d_w0_word", f),  a_out_word,  8'hFF);
      chk($sformatf("fr%0d_w0_last", f),  a_out_last,  0);
      pop_a();
      chk($sformatf("fr%0d_w1_word", f),  a_out_word,  8'h0F);
      chk($sformatf("fr%0d_w1_nbits", f), a_out_nbits, 4);
      chk($sformatf("fr%0d_w1_last", f),  a_out_last,  1);
      pop_a();
    end
    chk("fr_empty", a_out_valid, 0);
`ifdef BIT_PACKER_STATS_EN
    chk("stats_word_cnt",  a_wc, 4);
    chk("stats_frame_cnt", a_fc, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/bit_packer_param.md
BIT_PACKER_PARAM -- requirements
Module: bit_packer_param

Interface
REQ-001 Parameter OUT_W, default 8, output word width in bits; SHALL be >=2.
REQ-002 Parameter IN_W, default 1, decoded bits per input beat; SHALL divide OUT_W exactly (elaboration error otherwise).
REQ-003 Parameter FIFO_DEPTH, default 4, output FIFO entries; SHALL be a power of 2, >=2.
REQ-004 Parameter MSB_FIRST, default 0, bit order: 0 = first bit to word bit 0, 1 = first bit to bit OUT_W-1.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 in_bits  input  IN_W  decoded bits; bit 0 is earliest in time.
REQ-010 in_last  input  1  beat ends frame; flush partial word.
REQ-011 out_valid  output  1  FIFO head valid.
REQ-012 out_ready  input  1  sink accepts head.
REQ-013 out_word  output  OUT_W  packed word, unused positions zero.
REQ-014 out_nbits  output  $clog2(OUT_W)+1  count of valid bits in out_word.
REQ-015 out_last  output  1  word closes a frame.

Function
REQ-016 Beat transfer SHALL occur when in_valid && in_ready; out transfer when out_valid && out_ready.
REQ-017 in_ready SHALL equal (FIFO not full); no dependence on in_valid.
REQ-018 Accumulator SHALL append IN_W bits per transfer in order per MSB_FIRST, counting bit_cnt 0..OUT_W.
REQ-019 When a transfer fills OUT_W bits, the word SHALL be pushed to the FIFO same edge, out_nbits=OUT_W, out_last=in_last, accumulator cleared.
REQ-020 When in_last transfers with fewer than OUT_W total bits, the partial word SHALL be pushed, zero-padded, out_nbits=bits held, out_last=1.
REQ-021 Partial word with MSB_FIRST=1 SHALL be left-aligned (first bit at OUT_W-1); with MSB_FIRST=0 right-aligned.
REQ-022 Latency: word SHALL appear on out_valid the cycle after the completing transfer when FIFO was empty.
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged, including when full.
REQ-024 out_word/out_nbits/out_last SHALL be stable while out_valid && !out_ready.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; no word lost or duplicated.
REQ-026 Accepted input bits SHALL never be dropped (unlike single-bit predecessor).

Reset
REQ-027 On rst_n low: accumulator=0, bit_cnt=0, FIFO empty, out_valid=0, out_word=0, out_nbits=0, out_last=0, in_ready=0 while asserted.
REQ-028 Reset mid-frame SHALL discard partial word and FIFO contents; first beat after release starts a new word.

Configuration
REQ-029 Macro BIT_PACKER_STATS_EN defined: extra outputs word_cnt[15:0] (words popped, wrapping) and frame_cnt[15:0] (out_last words popped), both 0 on reset.
REQ-030 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared package viterbi_pkg SHALL hold default OUT_W/IN_W/FIFO_DEPTH constants and the stats counter width (16).
REQ-032 FIFO SHALL be sub-module pack_fifo (width OUT_W+$clog2(OUT_W)+2, depth FIFO_DEPTH).

Verification
REQ-033 Defaults, bits 1,0,1,1,0,0,1,0 in 8 beats, out_ready=1 -> out_word=8'h4D, out_nbits=8, out_last=0, one cycle after 8th beat.
REQ-034 Defaults, 3 beats 1,1,1 with in_last on 3rd -> out_word=8'h07, out_nbits=3, out_last=1; MSB_FIRST=1 -> 8'hE0.
REQ-035 IN_W=2, OUT_W=8, beats 2'b01,2'b10,2'b11,2'b00 -> out_word=8'h39.
REQ-036 out_ready=0, 40 continuous bits, FIFO_DEPTH=4 -> in_ready falls after 32 bits; release out_ready -> 5 words in order, none lost.
REQ-037 rst_n low after 5 bits, then 8 bits 0xFF -> single word 8'hFF, no residue.
REQ-038 BIT_PACKER_STATS_EN, 2 frames of 12 bits -> word_cnt=4, frame_cnt=2.
